// File: rtl/gear_shift_sequencer.sv
// rtl/gear_shift_sequencer.sv - one-step-at-a-time gear sequencer with req/ack actuator handshake
// Optional feature macro: BRAKE_INTERLOCK_EN (leaving P also requires brake applied)
module gear_shift_sequencer #(
    parameter int MAX_GEAR    = 5,
    parameter int MIN_DWELL   = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       park,
    input  logic       reverse,
    input  logic       drive,
    input  logic       brake,
    input  logic [3:0] rpm,
    input  logic       shift_ack,
    output logic       shift_req,
    output logic [2:0] gear_target,
    output logic [2:0] gear,
    output logic       reverse_lamp,
    output logic       fault
);

    localparam int DW = $clog2(MIN_DWELL) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    localparam logic [2:0]    GEAR_P    = 3'd0;
    localparam logic [2:0]    GEAR_R    = 3'd6;
    localparam logic [2:0]    GEAR_MAX  = 3'(MAX_GEAR);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [TW-1:0] TMO_MAX   = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        HOLD,
        REQ,
        FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [2:0]    gear_nxt, target_nxt, desired;
    logic          req_nxt, fault_nxt, lamp_nxt;
    logic          sel_valid, mode_change, brake_ok, interlock_ok, shift_go;
    logic [4:0]    rpm_w, gear_w;

    assign sel_valid = (park ^ reverse ^ drive) && !(park && reverse && drive);
    assign rpm_w     = {1'b0, rpm};
    assign gear_w    = {2'b00, gear};

    always_comb begin
        desired = GEAR_P;
        if (sel_valid) begin
            if (reverse) begin
                desired = GEAR_R;
            end else if (drive) begin
                if (gear == GEAR_P || gear == GEAR_R)
                    desired = 3'd1;
                else if (rpm_w >= gear_w + 5'd1 && gear < GEAR_MAX && !brake)
                    desired = gear + 3'd1;
                else if (rpm_w + 5'd1 <= gear_w && gear > 3'd1)
                    desired = gear - 3'd1;
                else
                    desired = gear;
            end
        end
    end

    // Any move touching P or R is a mode change: it bypasses dwell but needs a stopped engine.
    assign mode_change = (desired == GEAR_P) || (desired == GEAR_R) ||
                         (gear == GEAR_P) || (gear == GEAR_R);
`ifdef BRAKE_INTERLOCK_EN
    assign brake_ok = (gear != GEAR_P) || brake;
`else
    assign brake_ok = 1'b1;
`endif
    assign interlock_ok = !mode_change || (rpm == 4'd0 && brake_ok);
    assign shift_go     = (desired != gear) && interlock_ok &&
                          (mode_change || dwell == DWELL_MAX);

    always_comb begin
        state_nxt  = state;
        gear_nxt   = gear;
        target_nxt = gear_target;
        req_nxt    = shift_req;
        fault_nxt  = fault;
        dwell_nxt  = dwell;
        tmo_nxt    = tmo;
        case (state)
            HOLD: begin
                if (dwell != DWELL_MAX)
                    dwell_nxt = dwell + DW'(1);
                if (shift_go) begin
                    target_nxt = desired;
                    req_nxt    = 1'b1;
                    tmo_nxt    = '0;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                if (shift_ack) begin
                    gear_nxt  = gear_target;
                    req_nxt   = 1'b0;
                    dwell_nxt = '0;
                    state_nxt = HOLD;
                end else begin
                    if (tmo != TMO_MAX)
                        tmo_nxt = tmo + TW'(1);
                    if (tmo == TMO_LAST) begin
                        req_nxt   = 1'b0;
                        fault_nxt = 1'b1;
                        state_nxt = FAULT;
                    end
                end
            end
            FAULT: begin
                req_nxt = 1'b0;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = HOLD;
            end
        endcase
        lamp_nxt = (gear_nxt == GEAR_R);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD;
            gear         <= GEAR_P;
            gear_target  <= GEAR_P;
            shift_req    <= 1'b0;
            reverse_lamp <= 1'b0;
            fault        <= 1'b0;
            dwell        <= '0;
            tmo          <= '0;
        end else begin
            state        <= state_nxt;
            gear         <= gear_nxt;
            gear_target  <= target_nxt;
            shift_req    <= req_nxt;
            reverse_lamp <= lamp_nxt;
            fault        <= fault_nxt;
            dwell        <= dwell_nxt;
            tmo          <= tmo_nxt;
        end
    end

endmodule
